// File: rtl/sram_initiator.sv
// Single-outstanding initiator for a byte-masked single-port SRAM: legality check, byte-lane
// steering on the request side, alignment and sign/zero extension on the response side.
// Optional access counters (cnt_rd/cnt_wr) are built when SRAM_INITIATOR_CNT_EN is defined.
module sram_initiator #(
  parameter int LEN_ADDR = 32,
  parameter int LEN_DATA = 64,
  parameter int DEPTH    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [LEN_ADDR-1:0]   req_addr,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [LEN_DATA-1:0]   req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [LEN_DATA-1:0]   rsp_rdata,
  output logic                  rsp_err,
  output logic [LEN_ADDR-1:0]   sram_addra,
  output logic                  sram_ena,
  output logic [LEN_DATA/8-1:0] sram_wea,
  output logic [LEN_DATA-1:0]   sram_dina,
`ifdef SRAM_INITIATOR_CNT_EN
  output logic [31:0]           cnt_rd,
  output logic [31:0]           cnt_wr,
`endif
  input  logic [LEN_DATA-1:0]   sram_douta
);

  localparam int NB   = LEN_DATA / 8;
  localparam int OFFW = $clog2(NB);
  localparam logic [4:0]        NB_L  = 5'(NB);
  localparam logic [LEN_ADDR:0] LIMIT = (LEN_ADDR+1)'(DEPTH * NB);

  typedef enum logic [1:0] {IDLE = 2'd0, FRESH = 2'd1, HOLD = 2'd2} state_t;

  state_t              state_r;
  logic [OFFW-1:0]     off_r;
  logic [1:0]          size_r;
  logic                sgn_r;
  logic                we_r;
  logic                err_r;
  logic [LEN_DATA-1:0] hold_data_r;
  logic                hold_err_r;

  logic                accept_s;
  logic                legal_s;
  logic [OFFW-1:0]     off_s;
  logic [3:0]          nbytes_s;
  logic [15:0]         lane_mask_s;
  logic [LEN_DATA-1:0] fresh_data_s;

  // Truncate to 8<<size bits and extend back to the full word.
  function automatic logic [LEN_DATA-1:0] fmt(input logic [LEN_DATA-1:0] raw,
                                              input logic [1:0] size, input logic sgn);
    int   nbits;
    logic msb;
    nbits = ((8 << size) > LEN_DATA) ? LEN_DATA : (8 << size);
    msb   = raw[nbits-1];
    for (int i = 0; i < LEN_DATA; i++) begin
      fmt[i] = (i < nbits) ? raw[i] : (sgn & msb);
    end
  endfunction

  assign req_ready = (state_r == IDLE) | rsp_ready;
  assign accept_s  = req_valid & req_ready;
  assign off_s     = req_addr[OFFW-1:0];
  assign nbytes_s  = 4'd1 << req_size;
  assign legal_s   = ~(|(req_addr[3:0] & (nbytes_s - 4'd1)))
                   & ~({1'b0, nbytes_s} > NB_L)
                   & ({1'b0, req_addr} < LIMIT);
  assign lane_mask_s  = (16'd1 << nbytes_s) - 16'd1;
  assign fresh_data_s = fmt(sram_douta >> {off_r, 3'b000}, size_r, sgn_r);
  assign sram_addra   = req_addr;

  // SRAM port is only driven during a legal acceptance cycle.
  always_comb begin
    sram_ena = 1'b0;
    sram_wea = '0;
    sram_dina = '0;
    if (accept_s && legal_s) begin
      sram_ena = 1'b1;
      if (req_we) begin
        sram_wea  = NB'(lane_mask_s << off_s);
        sram_dina = req_wdata << {off_s, 3'b000};
      end else begin
        sram_wea  = '0;
        sram_dina = '0;
      end
    end else begin
      sram_ena = 1'b0;
    end
  end

  // Response mux: FRESH reads the SRAM output, HOLD replays the captured value.
  always_comb begin
    rsp_valid = (state_r != IDLE);
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (state_r)
      FRESH: begin
        rsp_rdata = (we_r | err_r) ? '0 : fresh_data_s;
        rsp_err   = err_r;
      end
      HOLD: begin
        rsp_rdata = hold_data_r;
        rsp_err   = hold_err_r;
      end
      default: begin
        rsp_rdata = '0;
        rsp_err   = 1'b0;
      end
    endcase
  end

  // Access FSM plus per-request attributes and stall capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      off_r       <= '0;
      size_r      <= 2'd0;
      sgn_r       <= 1'b0;
      we_r        <= 1'b0;
      err_r       <= 1'b0;
      hold_data_r <= '0;
      hold_err_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE:  state_r <= accept_s ? FRESH : IDLE;
        FRESH: begin
          if (rsp_ready) begin
            state_r <= accept_s ? FRESH : IDLE;
          end else begin
            state_r     <= HOLD;
            hold_data_r <= rsp_rdata;
            hold_err_r  <= err_r;
          end
        end
        HOLD:    state_r <= rsp_ready ? (accept_s ? FRESH : IDLE) : HOLD;
        default: state_r <= IDLE;
      endcase
      if (accept_s) begin
        off_r  <= off_s;
        size_r <= req_size;
        sgn_r  <= req_signed;
        we_r   <= req_we;
        err_r  <= ~legal_s;
      end
    end
  end

`ifdef SRAM_INITIATOR_CNT_EN
  logic [31:0] cnt_rd_r;
  logic [31:0] cnt_wr_r;

  // Legal load/store acceptance counters, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_rd_r <= 32'd0;
      cnt_wr_r <= 32'd0;
    end else if (accept_s && legal_s) begin
      if (req_we) cnt_wr_r <= cnt_wr_r + 32'd1;
      else        cnt_rd_r <= cnt_rd_r + 32'd1;
    end
  end

  assign cnt_rd = cnt_rd_r;
  assign cnt_wr = cnt_wr_r;
`endif

endmodule

// File: tb/tb_sram_initiator.sv
// Directed bench for sram_initiator with a behavioural write-first SRAM behind it.
module tb_sram_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] sram_addra;
  logic        sram_ena;
  logic [7:0]  sram_wea;
  logic [63:0] sram_dina;
  logic [63:0] sram_douta = 64'd0;
`ifdef SRAM_INITIATOR_CNT_EN
  logic [31:0] cnt_rd;
  logic [31:0] cnt_wr;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] mem [0:4095];

  sram_initiator dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_addra(sram_addra), .sram_ena(sram_ena), .sram_wea(sram_wea), .sram_dina(sram_dina),
`ifdef SRAM_INITIATOR_CNT_EN
    .cnt_rd(cnt_rd), .cnt_wr(cnt_wr),
`endif
    .sram_douta(sram_douta)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] din,
                                        input logic [7:0] we);
    merge = old;
    for (int b = 0; b < 8; b++) if (we[b]) merge[b*8 +: 8] = din[b*8 +: 8];
  endfunction

  always @(posedge clk) begin
    if (sram_ena) begin
      mem[sram_addra[14:3]] <= merge(mem[sram_addra[14:3]], sram_dina, sram_wea);
      sram_douta            <= merge(mem[sram_addra[14:3]], sram_dina, sram_wea);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated access: accept, then response one cycle later with rsp_ready=1.
  task automatic access(input string tag, input logic [31:0] addr, input logic we,
                        input logic [1:0] size, input logic sgn, input logic [63:0] wdata,
                        input logic exp_ena, input logic [7:0] exp_wea, input logic [63:0] exp_dina,
                        input logic [63:0] exp_rdata, input logic exp_err);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = addr; req_we = we; req_size = size;
    req_signed = sgn; req_wdata = wdata; rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, ".req_ready"}, {63'd0, req_ready}, 64'd1);
    check({tag, ".ena"}, {63'd0, sram_ena}, {63'd0, exp_ena});
    if (exp_ena) begin
      check({tag, ".wea"}, {56'd0, sram_wea}, {56'd0, exp_wea});
      check({tag, ".dina"}, sram_dina, exp_dina);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check({tag, ".rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
    check({tag, ".rdata"}, rsp_rdata, exp_rdata);
    check({tag, ".err"}, {63'd0, rsp_err}, {63'd0, exp_err});
  endtask

  logic [63:0] word_exp;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 64'd0;
    @(negedge clk);
    check("rst.req_ready", {63'd0, req_ready}, 64'd1);
    check("rst.rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst.rsp_err", {63'd0, rsp_err}, 64'd0);
    check("rst.rsp_rdata", rsp_rdata, 64'd0);
    check("rst.ena", {63'd0, sram_ena}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    access("st_d", 32'h10, 1'b1, 2'd3, 1'b0, 64'h1122334455667788,
           1'b1, 8'hFF, 64'h1122334455667788, 64'd0, 1'b0);
    access("ld_d", 32'h10, 1'b0, 2'd3, 1'b0, 64'd0,
           1'b1, 8'h00, 64'd0, 64'h1122334455667788, 1'b0);
    access("st_b", 32'h13, 1'b1, 2'd0, 1'b0, 64'h80,
           1'b1, 8'h08, 64'h0000_0000_8000_0000, 64'd0, 1'b0);
    access("ld_bs", 32'h13, 1'b0, 2'd0, 1'b1, 64'd0,
           1'b1, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    access("ld_bu", 32'h13, 1'b0, 2'd0, 1'b0, 64'd0,
           1'b1, 8'h00, 64'd0, 64'h80, 1'b0);
    access("ld_d2", 32'h10, 1'b0, 2'd3, 1'b0, 64'd0,
           1'b1, 8'h00, 64'd0, 64'h1122334480667788, 1'b0);
    access("mis_h", 32'h11, 1'b0, 2'd1, 1'b0, 64'd0,
           1'b0, 8'h00, 64'd0, 64'd0, 1'b1);
    access("oor", 32'h8000, 1'b0, 2'd3, 1'b0, 64'd0,
           1'b0, 8'h00, 64'd0, 64'd0, 1'b1);

    // Stall: word load held for 5 cycles while a second load waits.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h14; req_we = 1'b0; req_size = 2'd2;
    req_signed = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    check("stall.acc_ena", {63'd0, sram_ena}, 64'd1);
    @(posedge clk); #1;
    req_addr = 32'h10; req_size = 2'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall.rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("stall.rdata", rsp_rdata, 64'h11223344);
      check("stall.req_ready", {63'd0, req_ready}, 64'd0);
      check("stall.ena", {63'd0, sram_ena}, 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("release.req_ready", {63'd0, req_ready}, 64'd1);
    check("release.ena", {63'd0, sram_ena}, 64'd1);
    check("release.rdata", rsp_rdata, 64'h11223344);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("release.next", rsp_rdata, 64'h1122334480667788);

    // Streaming: 8 unsigned byte loads, one per cycle.
    word_exp = 64'h1122334480667788;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_addr = 32'h10 + 32'(i); req_size = 2'd0; req_signed = 1'b0;
      @(negedge clk);
      check("strm.req_ready", {63'd0, req_ready}, 64'd1);
      check("strm.ena", {63'd0, sram_ena}, 64'd1);
      if (i > 0) begin
        check("strm.rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("strm.rdata", rsp_rdata, (word_exp >> (8 * (i - 1))) & 64'hFF);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("strm.last", rsp_rdata, 64'h11);
    @(negedge clk);
    check("strm.idle", {63'd0, rsp_valid}, 64'd0);

    // Reset while FRESH.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h10; req_size = 2'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pre_rst.rsp_valid", {63'd0, rsp_valid}, 64'd1);
`ifdef SRAM_INITIATOR_CNT_EN
    check("pre_rst.cnt_rd", {32'd0, cnt_rd}, 64'd15);
    check("pre_rst.cnt_wr", {32'd0, cnt_wr}, 64'd2);
`endif
    rst = 1'b1;
    #1;
    check("arst.rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("arst.req_ready", {63'd0, req_ready}, 64'd1);
    check("arst.rdata", rsp_rdata, 64'd0);
`ifdef SRAM_INITIATOR_CNT_EN
    check("arst.cnt_rd", {32'd0, cnt_rd}, 64'd0);
    check("arst.cnt_wr", {32'd0, cnt_wr}, 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
